// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline front end.
package pipeline_pkg;

  localparam int          X_LEN     = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [X_LEN-1:0] pc;
    logic [31:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instr} pairs between imem and decode.
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo
  import pipeline_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Queue registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding a
// 2-entry queue that presents {pc, instr} to decode.
// Optional build macro IF_STAGE_BYPASS_EN: a response arriving while the
// queue is empty is forwarded to decode combinationally in the same cycle.
//
// state   | meaning
// IDLE    | no request outstanding
// REQ     | imem_req_o high, waiting for grant
// WAIT    | granted, waiting for rvalid
// DISCARD | granted before a redirect, response will be dropped
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [X_LEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             imem_req_o,
  output logic [X_LEN-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [X_LEN-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [X_LEN-1:0] pc_o,
  input  logic             instr_ready_i
);

  fetch_state_e     state_q, state_d;
  logic [X_LEN-1:0] pc_q, pc_d;
  logic [X_LEN-1:0] req_pc_q, req_pc_d;

  fetch_entry_t     push_data, head;
  logic [1:0]       count;
  logic             head_valid, push, pop, resp_accept, bypass_hit;

  assign head_valid  = (count != 2'd0);
  assign resp_accept = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign push_data   = '{pc: req_pc_q, instr: imem_rdata_i};

`ifdef IF_STAGE_BYPASS_EN
  assign bypass_hit = resp_accept && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word that decode takes immediately never enters the queue.
  assign push = resp_accept && !(bypass_hit && instr_ready_i);
  assign pop  = head_valid && instr_ready_i;

  fetch_fifo u_fetch_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (head),
    .count_o     (count)
  );

  // Decode-facing stream: queue head first, else bypassed response, else NOP.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = NOP_INSTR;
    pc_o          = '0;
    if (head_valid) begin
      instr_valid_o = 1'b1;
      instr_o       = head.instr;
      pc_o          = head.pc;
    end else if (bypass_hit) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      pc_o          = req_pc_q;
    end
  end

  // Fetch FSM next state and PC update; redirect overrides the PC last.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IDLE: begin
        if ((count < 2'd2) || redirect_i) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt_i) begin
          state_d  = redirect_i ? DISCARD : WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + X_LEN'(4);
        end else if (redirect_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rvalid_i)   state_d = IDLE;
        else if (redirect_i) state_d = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) pc_d = redirect_pc_i & ~X_LEN'(3);
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_q;

endmodule
